// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a small combinational circuit, holds each for DWELL cycles,
// samples Y at cycle SETTLE and packs the responses. Optional golden compare: TT_COMPARE_EN.
module truth_table_sequencer #(
    parameter int N_IN   = 3,
    parameter int DWELL  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic [N_IN-1:0]        vec,
    input  logic                   Y,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   resp
`ifdef TT_COMPARE_EN
    ,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   pass,
    output logic [N_IN-1:0]        err_idx
`endif
);

    localparam int N_VEC = 1 << N_IN;
    localparam int KW    = $clog2(DWELL);
    localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(N_VEC - 1);
    localparam logic [KW-1:0]   K_LAST    = KW'(DWELL - 1);
    localparam logic [KW-1:0]   K_SETTLE  = KW'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_IN-1:0]     r_vec;
    logic [KW-1:0]       r_k;
    logic                r_busy;
    logic                r_done;
    logic [N_VEC-1:0]    r_resp;
    logic [2:0]          w_abc;

    // Stimulus bits map LSB-first onto C,B,A; missing bits for small N_IN read as 0.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_abc
            if (gi < N_IN) begin : g_drv
                assign w_abc[gi] = r_vec[gi];
            end else begin : g_zero
                assign w_abc[gi] = 1'b0;
            end
        end
    endgenerate

    assign A    = w_abc[2];
    assign B    = w_abc[1];
    assign C    = w_abc[0];
    assign vec  = r_vec;
    assign busy = r_busy;
    assign done = r_done;
    assign resp = r_resp;

`ifdef TT_COMPARE_EN
    logic [N_VEC-1:0]    r_expected;
    logic                r_pass;
    logic [N_IN-1:0]     r_err_idx;
    logic [N_IN-1:0]     w_err_idx;

    // Scan downward so the lowest mismatching index is the one that sticks.
    always_comb begin
        w_err_idx = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (r_resp[i] != r_expected[i]) begin
                w_err_idx = N_IN'(i);
            end
        end
    end

    assign pass    = r_pass;
    assign err_idx = r_err_idx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_resp  <= '0;
`ifdef TT_COMPARE_EN
            r_expected <= '0;
            r_pass     <= 1'b0;
            r_err_idx  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_vec   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_resp  <= '0;
`ifdef TT_COMPARE_EN
                        r_expected <= expected;
                        r_pass     <= 1'b0;
                        r_err_idx  <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (r_k == K_SETTLE) begin
                        r_resp[r_vec] <= Y;
                    end
                    if (r_k == K_LAST) begin
                        r_k <= '0;
                        if (r_vec == VEC_LAST) begin
                            r_state <= ST_FIN;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
`ifdef TT_COMPARE_EN
                    r_pass    <= (r_resp == r_expected);
                    r_err_idx <= w_err_idx;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: table of circuit functions swept on a default instance,
// plus hand-written restart, abort, hold-start and DWELL=2 sequences. Honours TT_COMPARE_EN.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       a1, b1, c1, y1, busy1, done1;
    logic       a2, b2, c2, y2, busy2, done2;
    logic [2:0] vec1, vec2;
    logic [7:0] resp1, resp2;
    int         mode_sel = 0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

`ifdef TT_COMPARE_EN
    logic [7:0] expected1 = 8'h00;
    logic [7:0] expected2 = 8'h00;
    logic       pass1, pass2;
    logic [2:0] err_idx1, err_idx2;
`endif

    always #5 clk = ~clk;

    truth_table_sequencer #(.N_IN(3), .DWELL(4), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .C(c1), .vec(vec1), .Y(y1),
        .busy(busy1), .done(done1), .resp(resp1)
`ifdef TT_COMPARE_EN
        , .expected(expected1), .pass(pass1), .err_idx(err_idx1)
`endif
    );

    truth_table_sequencer #(.N_IN(3), .DWELL(2), .SETTLE(1)) u_dut_fast (
        .clk(clk), .rst(rst), .start(start2),
        .A(a2), .B(b2), .C(c2), .vec(vec2), .Y(y2),
        .busy(busy2), .done(done2), .resp(resp2)
`ifdef TT_COMPARE_EN
        , .expected(expected2), .pass(pass2), .err_idx(err_idx2)
`endif
    );

    function automatic logic eval_y(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return a & b & c;
            1:       return a | b | c;
            2:       return a ^ b ^ c;
            3:       return ~(a | b | c);
            4:       return (a & b) | (a & c) | (b & c);
            5:       return a;
            default: return c;
        endcase
    endfunction

    assign y1 = eval_y(mode_sel, a1, b1, c1);
    assign y2 = a2 ^ b2 ^ c2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sweep on the default instance; restarts ra/rb are start pulses at those edges (-1 = none).
    task automatic do_sweep(input string name, input int mode, input logic [7:0] exp_resp,
                            input int ra, input int rb);
        int busy_cnt;
        int done_edge;
        bit vec_bad;
        logic [7:0] exp_v;
        mode_sel = mode;
        exp_q.push_back(exp_resp);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({name, "_start_busy"}, {31'd0, busy1}, 32'd1);
        check({name, "_start_done"}, {31'd0, done1}, 32'd0);
        check({name, "_start_resp"}, {24'd0, resp1}, 32'd0);
        busy_cnt  = busy1 ? 1 : 0;
        done_edge = -1;
        vec_bad   = 1'b0;
        for (int j = 1; j <= 45 && done_edge < 0; j++) begin
            start1 = (j == ra || j == rb);
            tick();
            start1 = 1'b0;
            if (busy1) busy_cnt++;
            if (j < 32 && (vec1 !== 3'(j / 4) || {a1, b1, c1} !== vec1)) vec_bad = 1'b1;
            if (done1) done_edge = j;
        end
        check({name, "_vec_seq"}, {31'd0, vec_bad}, 32'd0);
        check({name, "_done_edge"}, done_edge, 32'd33);
        check({name, "_busy_cycles"}, busy_cnt, 32'd32);
        check({name, "_idle_vec"}, {29'd0, vec1}, 32'd0);
        if (exp_q.size() == 0) begin
            check({name, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp_v = exp_q.pop_front();
            check({name, "_resp"}, {24'd0, resp1}, {24'd0, exp_v});
        end
        $display("sweep %s: resp=%02h done_edge=%0d busy_cycles=%0d", name, resp1, done_edge, busy_cnt);
    endtask

    typedef struct {
        string      name;
        int         mode;
        logic [7:0] exp_resp;
    } vec_rec_t;

    vec_rec_t tbl[7];

    initial begin
        int d_edge;
        int b_cnt;
        logic [7:0] held;

        tbl[0] = '{"and3", 0, 8'h80};
        tbl[1] = '{"or3",  1, 8'hFE};
        tbl[2] = '{"xor3", 2, 8'h96};
        tbl[3] = '{"nor3", 3, 8'h01};
        tbl[4] = '{"maj3", 4, 8'hE8};
        tbl[5] = '{"a_only", 5, 8'hF0};
        tbl[6] = '{"c_only", 6, 8'hAA};

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_resp", {24'd0, resp1}, 32'd0);
        check("rst_vec",  {29'd0, vec1}, 32'd0);
        check("rst_abc",  {29'd0, a1, b1, c1}, 32'd0);
        $display("reset: busy=%0b done=%0b resp=%02h vec=%0d", busy1, done1, resp1, vec1);

        for (int i = 0; i < 7; i++) begin
            do_sweep(tbl[i].name, tbl[i].mode, tbl[i].exp_resp, -1, -1);
        end

        // done is a level and resp stays frozen while idle
        held = resp1;
        repeat (3) tick();
        check("done_hold", {31'd0, done1}, 32'd1);
        check("resp_hold", {24'd0, resp1}, {24'd0, held});
        check("idle_busy", {31'd0, busy1}, 32'd0);

        do_sweep("restart_ignored", 1, 8'hFE, 5, 20);

        // Abort mid-sweep
        mode_sel = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_done", {31'd0, done1}, 32'd0);
        check("abort_resp", {24'd0, resp1}, 32'd0);
        check("abort_vec",  {29'd0, vec1}, 32'd0);
        $display("abort: busy=%0b done=%0b resp=%02h vec=%0d", busy1, done1, resp1, vec1);
        do_sweep("after_abort", 0, 8'h80, -1, -1);

        // start held high: a fresh sweep begins the edge after done rises
        mode_sel = 0;
        start1 = 1'b1;
        tick();
        repeat (33) tick();
        check("hold_done_rise", {31'd0, done1}, 32'd1);
        check("hold_resp", {24'd0, resp1}, 32'h80);
        tick();
        check("hold_restart_busy", {31'd0, busy1}, 32'd1);
        check("hold_restart_done", {31'd0, done1}, 32'd0);
        check("hold_restart_resp", {24'd0, resp1}, 32'd0);
        $display("hold_start: busy=%0b done=%0b resp=%02h", busy1, done1, resp1);
        start1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // DWELL=2, SETTLE=1 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        b_cnt  = busy2 ? 1 : 0;
        d_edge = -1;
        for (int j = 1; j <= 30 && d_edge < 0; j++) begin
            tick();
            if (busy2) b_cnt++;
            if (done2) d_edge = j;
        end
        check("fast_done_edge", d_edge, 32'd17);
        check("fast_busy_cycles", b_cnt, 32'd16);
        check("fast_resp", {24'd0, resp2}, 32'h96);
        $display("sweep fast_xor3: resp=%02h done_edge=%0d busy_cycles=%0d", resp2, d_edge, b_cnt);

`ifdef TT_COMPARE_EN
        expected1 = 8'h80;
        do_sweep("cmp_match", 0, 8'h80, -1, -1);
        check("cmp_match_pass", {31'd0, pass1}, 32'd1);
        check("cmp_match_err",  {29'd0, err_idx1}, 32'd0);
        expected1 = 8'h88;
        do_sweep("cmp_mismatch", 0, 8'h80, -1, -1);
        check("cmp_mismatch_pass", {31'd0, pass1}, 32'd0);
        check("cmp_mismatch_err",  {29'd0, err_idx1}, 32'd3);
        $display("compare: pass=%0b err_idx=%0d", pass1, err_idx1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
